regfile_mp: RTL and testbench

- Parametrised, dual-write-port successor to the processor's single-write register file.
- Sits in decode/writeback: two combinational read ports feed operand fetch; two write ports take ALU and memory writeback.
- Adds:
  - optional hard-wired zero register
  - write-to-read bypass
  - write-port priority
  - a sequential clear engine, run after reset or on request, that zeroes every entry and reports readiness

---
 rtl/regfile_mp.sv | 126 ++++++++++++
 tb/tb_regfile_mp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Dual-write, dual-read register file with bypass, write-port priority,
// optional hard-wired zero entry and a sequential clear engine.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic [ADDR_W-1:0] dst0,
    input  logic [DATA_W-1:0] wData0,
    input  logic              writeEnable0,
    input  logic [ADDR_W-1:0] dst1,
    input  logic [DATA_W-1:0] wData1,
    input  logic              writeEnable1,
    input  logic              clr,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic              ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic wr_en;
    logic clr_en;
    logic we0_ok;
    logic we1_ok;

    // An address is usable if it maps to a real entry and is not the zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_en  = rst && (state_q == ST_IDLE);
    assign clr_en = rst && (state_q == ST_CLEAR);
    assign we0_ok = writeEnable0 && wr_en && addr_ok(dst0);
    assign we1_ok = writeEnable1 && wr_en && addr_ok(dst1);
    assign ready  = (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Clear engine overrides writes; port 1 beats port 0 on the same entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (clr_en && (idx_q == ADDR_W'(i))) begin
                mem_q[i] <= '0;
            end else if (we1_ok && (dst1 == ADDR_W'(i))) begin
                mem_q[i] <= wData1;
            end else if (we0_ok && (dst0 == ADDR_W'(i))) begin
                mem_q[i] <= wData0;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] src);
        logic [DATA_W-1:0] val;
        val = '0;
        if (state_q == ST_IDLE) begin
            if (addr_ok(src)) begin
                val = mem_q[src];
            end
            if (BYPASS != 0) begin
                if (we1_ok && (dst1 == src)) begin
                    val = wData1;
                end else if (we0_ok && (dst0 == src)) begin
                    val = wData0;
                end
            end
        end
        return val;
    endfunction

    always_comb begin
        data1 = '0;
        data1 = read_port(src1);
    end

    always_comb begin
        data2 = '0;
        data2 = read_port(src2);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default, no-bypass and DEPTH=24 instances
// share one stimulus bus; expected values are queued at drive time.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] src1, src2, dst0, dst1;
    logic [DW-1:0] wData0, wData1;
    logic          writeEnable0, writeEnable1, clr;
    logic [DW-1:0] d1_a, d2_a, d1_b, d2_b, d1_c, d2_c;
    logic          rdy_a, rdy_b, rdy_c;

    int            n_cmp;
    int            n_err;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] expv;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2),
        .dst0(dst0), .wData0(wData0), .writeEnable0(writeEnable0),
        .dst1(dst1), .wData1(wData1), .writeEnable1(writeEnable1),
        .clr(clr), .data1(d1_a), .data2(d2_a), .ready(rdy_a)
    );

    regfile_mp #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2),
        .dst0(dst0), .wData0(wData0), .writeEnable0(writeEnable0),
        .dst1(dst1), .wData1(wData1), .writeEnable1(writeEnable1),
        .clr(clr), .data1(d1_b), .data2(d2_b), .ready(rdy_b)
    );

    regfile_mp #(.DEPTH(24)) u_d24 (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2),
        .dst0(dst0), .wData0(wData0), .writeEnable0(writeEnable0),
        .dst1(dst1), .wData1(wData1), .writeEnable1(writeEnable1),
        .clr(clr), .data1(d1_c), .data2(d2_c), .ready(rdy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int ca, cb, cc;
        rst = 1'b0; clr = 1'b0;
        writeEnable0 = 1'b0; writeEnable1 = 1'b0;
        dst0 = '0; dst1 = '0; wData0 = '0; wData1 = '0; src1 = '0; src2 = '0;
        @(posedge clk);
        tick();
        exp_q.push_back(32'd0);
        expv = exp_q.pop_front(); n_cmp++;
        if (DW'(rdy_a | rdy_b | rdy_c) !== expv) begin
            n_err++; $display("FAIL reset_ready: got %0b%0b%0b want 0", rdy_a, rdy_b, rdy_c);
        end
        rst = 1'b1;
        ca = 0; cb = 0; cc = 0;
        exp_q.push_back(32'd32); exp_q.push_back(32'd32); exp_q.push_back(32'd24);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!rdy_a) ca++;
            if (!rdy_b) cb++;
            if (!rdy_c) cc++;
            if (rdy_a && rdy_b && rdy_c) break;
        end
        tick();
        expv = exp_q.pop_front(); n_cmp++;
        if (DW'(ca) !== expv) begin n_err++; $display("FAIL reset_clear_a: got %0d want %0d", ca, expv); end
        expv = exp_q.pop_front(); n_cmp++;
        if (DW'(cb) !== expv) begin n_err++; $display("FAIL reset_clear_b: got %0d want %0d", cb, expv); end
        expv = exp_q.pop_front(); n_cmp++;
        if (DW'(cc) !== expv) begin n_err++; $display("FAIL reset_clear_c: got %0d want %0d", cc, expv); end
        for (int i = 0; i < 32; i++) begin
            src1 = AW'(i); src2 = AW'(31 - i);
            exp_q.push_back(32'd0); exp_q.push_back(32'd0);
            @(negedge clk);
            expv = exp_q.pop_front(); n_cmp++;
            if (d1_a !== expv) begin n_err++; $display("FAIL reset_read1 r%0d: got %h want %h", i, d1_a, expv); end
            expv = exp_q.pop_front(); n_cmp++;
            if (d2_a !== expv) begin n_err++; $display("FAIL reset_read2 r%0d: got %h want %h", 31 - i, d2_a, expv); end
            tick();
        end
    endtask

    task automatic test_write_zero();
        writeEnable0 = 1'b1; dst0 = 5'd5; wData0 = 32'hDEADBEEF;
        writeEnable1 = 1'b1; dst1 = 5'd0; wData1 = 32'h12345678;
        src1 = 5'd5; src2 = 5'd0;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
            @(negedge clk);
            expv = exp_q.pop_front(); n_cmp++;
            if (d1_a !== expv) begin n_err++; $display("FAIL wr_r5 cyc%0d: got %h want %h", c, d1_a, expv); end
            expv = exp_q.pop_front(); n_cmp++;
            if (d2_a !== expv) begin n_err++; $display("FAIL zero_reg cyc%0d: got %h want %h", c, d2_a, expv); end
            tick();
            writeEnable0 = 1'b0; writeEnable1 = 1'b0;
        end
    endtask

    task automatic test_conflict();
        writeEnable0 = 1'b1; dst0 = 5'd7; wData0 = 32'hAAAA0000;
        writeEnable1 = 1'b1; dst1 = 5'd7; wData1 = 32'h0000BBBB;
        src1 = 5'd7;
        exp_q.push_back(32'h0000BBBB); exp_q.push_back(32'h0);
        @(negedge clk);
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_a !== expv) begin n_err++; $display("FAIL conflict_byp: got %h want %h", d1_a, expv); end
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_b !== expv) begin n_err++; $display("FAIL conflict_nobyp: got %h want %h", d1_b, expv); end
        tick();
        writeEnable0 = 1'b0; writeEnable1 = 1'b0;
        exp_q.push_back(32'h0000BBBB); exp_q.push_back(32'h0000BBBB);
        @(negedge clk);
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_a !== expv) begin n_err++; $display("FAIL conflict_after_a: got %h want %h", d1_a, expv); end
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_b !== expv) begin n_err++; $display("FAIL conflict_after_b: got %h want %h", d1_b, expv); end
        tick();
    endtask

    task automatic test_bypass_off();
        writeEnable0 = 1'b1; dst0 = 5'd3; wData0 = 32'h11; src1 = 5'd3;
        tick();
        wData0 = 32'h22;
        exp_q.push_back(32'h11); exp_q.push_back(32'h22);
        @(negedge clk);
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_b !== expv) begin n_err++; $display("FAIL nobyp_write_cyc: got %h want %h", d1_b, expv); end
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_a !== expv) begin n_err++; $display("FAIL byp_write_cyc: got %h want %h", d1_a, expv); end
        tick();
        writeEnable0 = 1'b0;
        exp_q.push_back(32'h22);
        @(negedge clk);
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_b !== expv) begin n_err++; $display("FAIL nobyp_next_cyc: got %h want %h", d1_b, expv); end
        tick();
    endtask

    task automatic test_clear_mid();
        int ca;
        for (int i = 1; i < 32; i++) begin
            writeEnable0 = 1'b1; dst0 = AW'(i); wData0 = 32'hA5000000 | DW'(i);
            tick();
        end
        writeEnable0 = 1'b0; src1 = 5'd31; src2 = 5'd1;
        exp_q.push_back(32'hA500001F); exp_q.push_back(32'hA5000001);
        @(negedge clk);
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_a !== expv) begin n_err++; $display("FAIL fill_r31: got %h want %h", d1_a, expv); end
        expv = exp_q.pop_front(); n_cmp++;
        if (d2_a !== expv) begin n_err++; $display("FAIL fill_r1: got %h want %h", d2_a, expv); end
        tick();
        clr = 1'b1; writeEnable0 = 1'b1; dst0 = 5'd9; wData0 = 32'h55; src1 = 5'd9;
        exp_q.push_back(32'h55);
        @(negedge clk);
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_a !== expv) begin n_err++; $display("FAIL clr_cycle_write: got %h want %h", d1_a, expv); end
        tick();
        clr = 1'b0; dst0 = 5'd4; wData0 = 32'h99; src1 = 5'd4; src2 = 5'd9;
        ca = 0;
        exp_q.push_back(32'h0); exp_q.push_back(32'd32);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) begin
                expv = exp_q.pop_front(); n_cmp++;
                if (d1_a !== expv) begin n_err++; $display("FAIL read_in_clear: got %h want %h", d1_a, expv); end
            end
            if (rdy_a) begin
                writeEnable0 = 1'b0;
                break;
            end
            ca++;
        end
        tick();
        expv = exp_q.pop_front(); n_cmp++;
        if (DW'(ca) !== expv) begin n_err++; $display("FAIL clr_ready_len: got %0d want %0d", ca, expv); end
        for (int i = 0; i < 32; i++) begin
            src1 = AW'(i); src2 = AW'(31 - i);
            exp_q.push_back(32'd0); exp_q.push_back(32'd0);
            @(negedge clk);
            expv = exp_q.pop_front(); n_cmp++;
            if (d1_a !== expv) begin n_err++; $display("FAIL clr_read1 r%0d: got %h want %h", i, d1_a, expv); end
            expv = exp_q.pop_front(); n_cmp++;
            if (d2_a !== expv) begin n_err++; $display("FAIL clr_read2 r%0d: got %h want %h", 31 - i, d2_a, expv); end
            tick();
        end
    endtask

    task automatic test_d24();
        int cc;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        exp_q.push_back(32'h0);
        expv = exp_q.pop_front(); n_cmp++;
        if (DW'(rdy_c) !== expv) begin n_err++; $display("FAIL d24_midclear_ready: got %0b want 0", rdy_c); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cc = 0;
        exp_q.push_back(32'd24);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rdy_c) break;
            cc++;
        end
        tick();
        expv = exp_q.pop_front(); n_cmp++;
        if (DW'(cc) !== expv) begin n_err++; $display("FAIL d24_restart_len: got %0d want %0d", cc, expv); end
        while (!(rdy_a && rdy_b)) tick();
        writeEnable1 = 1'b1; dst1 = 5'd1; wData1 = 32'hCAFE0001;
        tick();
        writeEnable1 = 1'b0;
        writeEnable0 = 1'b1; dst0 = 5'd25; wData0 = 32'hFF; src1 = 5'd25; src2 = 5'd1;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(32'h0); exp_q.push_back(32'hCAFE0001);
            @(negedge clk);
            expv = exp_q.pop_front(); n_cmp++;
            if (d1_c !== expv) begin n_err++; $display("FAIL d24_oor_read cyc%0d: got %h want %h", c, d1_c, expv); end
            expv = exp_q.pop_front(); n_cmp++;
            if (d2_c !== expv) begin n_err++; $display("FAIL d24_alias_r1 cyc%0d: got %h want %h", c, d2_c, expv); end
            tick();
            writeEnable0 = 1'b0;
        end
        writeEnable1 = 1'b1; dst1 = 5'd23; wData1 = 32'h23;
        writeEnable0 = 1'b1; dst0 = 5'd24; wData0 = 32'h24;
        src1 = 5'd23; src2 = 5'd24;
        exp_q.push_back(32'h23); exp_q.push_back(32'h0);
        @(negedge clk);
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_c !== expv) begin n_err++; $display("FAIL d24_last_byp: got %h want %h", d1_c, expv); end
        expv = exp_q.pop_front(); n_cmp++;
        if (d2_c !== expv) begin n_err++; $display("FAIL d24_first_oor: got %h want %h", d2_c, expv); end
        tick();
        writeEnable0 = 1'b0; writeEnable1 = 1'b0;
        exp_q.push_back(32'h23); exp_q.push_back(32'h0);
        @(negedge clk);
        expv = exp_q.pop_front(); n_cmp++;
        if (d1_c !== expv) begin n_err++; $display("FAIL d24_last_stored: got %h want %h", d1_c, expv); end
        expv = exp_q.pop_front(); n_cmp++;
        if (d2_c !== expv) begin n_err++; $display("FAIL d24_oor_stored: got %h want %h", d2_c, expv); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write_zero();
        test_conflict();
        test_bypass_off();
        test_clear_mid();
        test_d24();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
